fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Desc   : RV32 fetch stage - PC stream, imem request issue, prefetch queue,
//          decode handoff and branch redirect with in-flight discard.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_incr
);

  localparam int c_cnt_w = $clog2(MAX_OUTSTANDING) + 1;
  localparam int c_q_w   = $clog2(QUEUE_DEPTH) + 1;
  localparam int c_ptr_w = $clog2(QUEUE_DEPTH);

  localparam logic [XLEN-1:0]    c_pc_step = XLEN'(4);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_q_w-1:0]   c_q_one   = c_q_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [XLEN-1:0]    r_fetch_pc;
  logic [XLEN-1:0]    r_rsp_pc;
  logic [c_cnt_w-1:0] r_outstanding;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic [c_q_w-1:0]   r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [31:0]        r_q_instr [QUEUE_DEPTH];
  logic [XLEN-1:0]    r_q_pc    [QUEUE_DEPTH];

  logic               w_can_issue;
  logic               w_req_fire;
  logic               w_rsp_take;
  logic               w_push;
  logic               w_pop;
  logic [c_cnt_w-1:0] w_out_next;
  logic [XLEN-1:0]    w_redirect_pc;

  // Every issued request has a reserved queue slot, so a response never overflows.
  assign w_can_issue = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                       (int'(r_outstanding) + int'(r_count) < QUEUE_DEPTH);

  assign imem_req_valid = rst_n && w_can_issue;
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire    = imem_req_valid && imem_req_ready;
  assign w_rsp_take    = imem_rsp_valid && (r_outstanding != '0);
  assign w_push        = w_rsp_take && (r_drop_cnt == '0) && !redirect_valid;
  assign w_pop         = id_valid && id_ready;
  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};

  always_comb begin
    w_out_next = r_outstanding;
    if (w_req_fire) w_out_next = w_out_next + c_cnt_one;
    if (w_rsp_take) w_out_next = w_out_next - c_cnt_one;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= w_out_next;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_pc_step;
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + c_pc_step;
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_rsp_take && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - c_cnt_one;
        if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        if (w_push && !w_pop)      r_count <= r_count + c_q_one;
        else if (!w_push && w_pop) r_count <= r_count - c_q_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_rsp_pc;
    end
  end

  // Head fields read as zero while the queue is empty (including reset).
  assign id_valid   = (r_count != '0);
  assign id_instr   = id_valid ? r_q_instr[r_rd_ptr] : '0;
  assign id_pc      = id_valid ? r_q_pc[r_rd_ptr] : '0;
  assign id_pc_incr = id_valid ? (r_q_pc[r_rd_ptr] + c_pc_step) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Desc   : Randomised bench for fetch_unit with an epoch-based fetch model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_incr;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_incr(id_pc_incr)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];      // accepted, not yet answered by memory
  logic [31:0] mq[$];        // PCs the decode side should see, in order
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0, epoch = 0, discards = 0;
  int          lat = 1;
  bit          lat_rand = 1'b0;
  int          spur_req = 0, spur_ack = 0;
  logic [31:0] exp_fetch = RESET_PC;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  bit          want_acc = 1'b0, want_pop = 1'b0;
  logic [31:0] post_rd_acc, post_rd_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // Memory responder and reference model; every response from an older
  // epoch, or arriving in a redirect cycle, must never reach decode.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete(); mq.delete(); acc_log.delete(); pop_log.delete();
      exp_fetch = RESET_PC; prev_hold = 1'b0; want_acc = 1'b0; want_pop = 1'b0;
      imem_rsp_valid = 1'b0; spur_ack = spur_req;
    end else begin : model
      bit          exp_rv;
      req_t        r;
      exp_rv = (pend.size() < MAXO) && (pend.size() + mq.size() < DEPTH);
      n_vec++;
      if (imem_req_valid !== exp_rv) begin
        n_err++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
      end
      n_vec++;
      if (imem_req_addr !== exp_fetch) begin
        n_err++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_fetch);
      end
      if (prev_hold) begin
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          n_err++; $display("FAIL req_hold cyc=%0d got=%b/%h exp=1/%h", cyc, imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      n_vec++;
      if (id_valid !== (mq.size() != 0)) begin
        n_err++; $display("FAIL id_valid cyc=%0d got=%b exp=%b", cyc, id_valid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_vec++;
        if (id_pc !== mq[0] || id_instr !== mem_word(mq[0]) || id_pc_incr !== mq[0] + 32'd4) begin
          n_err++; $display("FAIL id_head cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, id_pc, id_instr,
                            id_pc_incr, mq[0], mem_word(mq[0]), mq[0] + 32'd4);
        end
      end
      // decode pop happens on the same edge, before this cycle's push
      if (id_valid && id_ready && mq.size() != 0) begin
        pop_log.push_back(mq[0]);
        if (want_pop) begin post_rd_pop = mq[0]; want_pop = 1'b0; end
        void'(mq.pop_front());
      end
      imem_rsp_valid = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack = spur_req;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      end else if (pend.size() != 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(r.addr);
        if (r.epoch == epoch && !redirect_valid) mq.push_back(r.addr);
        else discards++;
      end
      if (imem_req_valid && imem_req_ready) begin
        acc_log.push_back(imem_req_addr);
        if (want_acc) begin post_rd_acc = imem_req_addr; want_acc = 1'b0; end
        r.addr  = exp_fetch;
        r.epoch = epoch;
        r.due   = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
        pend.push_back(r);
        exp_fetch = exp_fetch + 32'd4;
      end
      if (redirect_valid) begin
        epoch++;
        mq.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
        want_acc = 1'b1; want_pop = 1'b1;
      end
      prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
      prev_addr = imem_req_addr;
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    n_vec++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_id_valid got=%b exp=0", id_valid); end
    n_vec++; if (imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL rst_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    n_vec++;
    if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_incr !== 32'h0) begin
      n_err++; $display("FAIL rst_id_fields got=%h/%h/%h exp=0/0/0", id_pc, id_instr, id_pc_incr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    lat = 1; lat_rand = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (acc_log.size() <= i || acc_log[i] !== 32'(i * 4)) begin
        n_err++; $display("FAIL seq_req[%0d] got=%h exp=%h", i, (acc_log.size() > i) ? acc_log[i] : 32'hx, 32'(i * 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
        n_err++; $display("FAIL seq_pop[%0d] got=%h exp=%h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    int a0, p0;
    logic [31:0] nxt;
    id_ready = 1'b0;
    repeat (20) tick();
    a0 = acc_log.size();
    repeat (5) tick();
    n_vec++; if (acc_log.size() != a0) begin n_err++; $display("FAIL stall_issue got=%0d exp=%0d", acc_log.size(), a0); end
    n_vec++; if (id_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL stall_full got=%b/%b exp=1/0", id_valid, imem_req_valid);
    end
    p0 = pop_log.size();
    nxt = (p0 > 0) ? pop_log[p0 - 1] + 32'd4 : 32'hx;
    id_ready = 1'b1;
    repeat (4) tick();
    n_vec++; if (pop_log.size() != p0 + 4) begin n_err++; $display("FAIL stall_drain got=%0d exp=%0d", pop_log.size() - p0, 4); end
    repeat (8) tick();
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (pop_log.size() <= p0 + i || pop_log[p0 + i] !== nxt + 32'(4 * i)) begin
        n_err++; $display("FAIL stall_seq[%0d] got=%h exp=%h", i,
                          (pop_log.size() > p0 + i) ? pop_log[p0 + i] : 32'hx, nxt + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_latency();
    bit found = 1'b0;
    int d0;
    rst_n = 1'b0; tick(); tick();
    lat = 3; imem_req_ready = 1'b1; id_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (pend.size() == 2 && pend[1].addr == 32'h14 && pend[0].due > cyc) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL rdl_setup got=0 exp=1"); end
    d0 = discards;
    redirect_pc = 32'h102; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rdl_flush got=%b exp=0", id_valid); end
    repeat (12) tick();
    n_vec++; if (discards - d0 != 2) begin n_err++; $display("FAIL rdl_drops got=%0d exp=2", discards - d0); end
    n_vec++; if (post_rd_acc !== 32'h100) begin n_err++; $display("FAIL rdl_req got=%h exp=00000100", post_rd_acc); end
    n_vec++; if (post_rd_pop !== 32'h100) begin n_err++; $display("FAIL rdl_pop got=%h exp=00000100", post_rd_pop); end
  endtask

  task automatic test_redirect_collision();
    bit found = 1'b0;
    int d0;
    lat = 1; imem_req_ready = 1'b1; id_ready = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (imem_req_valid && pend.size() == 1 && pend[0].due <= cyc) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL col_setup got=0 exp=1"); end
    d0 = discards;
    redirect_pc = 32'h200; redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    n_vec++; if (discards - d0 != 2) begin n_err++; $display("FAIL col_drops got=%0d exp=2", discards - d0); end
    n_vec++; if (post_rd_acc !== 32'h200) begin n_err++; $display("FAIL col_req got=%h exp=00000200", post_rd_acc); end
    n_vec++; if (post_rd_pop !== 32'h200) begin n_err++; $display("FAIL col_pop got=%h exp=00000200", post_rd_pop); end
  endtask

  task automatic test_back_to_back();
    repeat (3) tick();
    redirect_pc = 32'h301; redirect_valid = 1'b1;
    tick();
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    n_vec++; if (post_rd_acc !== 32'h400) begin n_err++; $display("FAIL b2b_req got=%h exp=00000400", post_rd_acc); end
    n_vec++; if (post_rd_pop !== 32'h400) begin n_err++; $display("FAIL b2b_pop got=%h exp=00000400", post_rd_pop); end
  endtask

  task automatic test_spurious();
    bit found = 1'b0;
    int p0;
    imem_req_ready = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (pend.size() == 0 && !id_valid) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL spur_setup got=0 exp=1"); end
    spur_req++;
    tick(); tick();
    n_vec++; if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL spur_underflow got=%b exp=1", imem_req_valid); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL spur_push got=%b exp=0", id_valid); end
    p0 = pop_log.size();
    imem_req_ready = 1'b1;
    repeat (8) tick();
    n_vec++; if (pop_log.size() < p0 + 4) begin n_err++; $display("FAIL spur_resume got=%0d exp>=4", pop_log.size() - p0); end
  endtask

  task automatic test_random();
    int p0 = pop_log.size();
    lat_rand = 1'b1;
    for (int i = 0; i < 600; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      if (i == 300) begin
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF6;
      end else if ($urandom_range(0, 29) == 0) begin
        redirect_valid = 1'b1; redirect_pc = $urandom();
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0; lat_rand = 1'b0;
    n_vec++; if (pop_log.size() < p0 + 50) begin n_err++; $display("FAIL rand_progress got=%0d exp>=50", pop_log.size() - p0); end
  endtask

  task automatic test_reset_midop();
    bit found = 1'b0;
    lat = 3; imem_req_ready = 1'b1; id_ready = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (mq.size() >= 2 && pend.size() >= 1 && mq.size() + pend.size() == DEPTH) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_setup got=0 exp=1"); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_valids got=%b/%b exp=0/0", imem_req_valid, id_valid);
    end
    n_vec++; if (imem_req_addr !== RESET_PC) begin n_err++; $display("FAIL mid_addr got=%h exp=%h", imem_req_addr, RESET_PC); end
    n_vec++; if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_pc_incr !== 32'h0) begin
      n_err++; $display("FAIL mid_fields got=%h/%h/%h exp=0/0/0", id_pc, id_instr, id_pc_incr);
    end
    tick();
    rst_n = 1'b1; id_ready = 1'b1; lat = 1;
    repeat (4) tick();
    n_vec++; if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin
      n_err++; $display("FAIL mid_first_req got=%h exp=%h", (acc_log.size() > 0) ? acc_log[0] : 32'hx, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_latency();
    test_redirect_collision();
    test_back_to_back();
    test_spurious();
    test_random();
    test_reset_midop();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
